// File: rtl/bmu_txn_capture.sv
// bmu_txn_capture: pairs each issued BMU operation with its registered
// result RESULT_LAT cycles later and queues the completed transaction in a
// FIFO drained over a ready/valid stream.
// Optional feature macro: BMU_TXN_CSR_EN (capture CSR-read operations and
// carry csr_rddata_in through to txn_csr_data).
module bmu_txn_capture #(
  parameter int RESULT_LAT = 1,
  parameter int DEPTH      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    valid_in,
  input  logic                    scan_mode,
  input  logic [31:0]             a_in,
  input  logic [31:0]             b_in,
  input  logic [21:0]             ap_in,
  input  logic                    csr_ren_in,
  input  logic [31:0]             csr_rddata_in,
  input  logic [31:0]             result_ff,
  input  logic                    error,
  output logic                    txn_valid,
  input  logic                    txn_ready,
  output logic [31:0]             txn_a,
  output logic [31:0]             txn_b,
  output logic [21:0]             txn_ap,
  output logic [31:0]             txn_result,
  output logic                    txn_error,
`ifdef BMU_TXN_CSR_EN
  output logic [31:0]             txn_csr_data,
`endif
  output logic                    overflow,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [$clog2(DEPTH):0]  fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [21:0] ap;
    logic [31:0] result;
    logic        err;
`ifdef BMU_TXN_CSR_EN
    logic [31:0] csr;
`endif
  } txn_t;

  logic                  cap;
  logic [RESULT_LAT-1:0] pipe_vld;
  logic [31:0]           pipe_a  [RESULT_LAT];
  logic [31:0]           pipe_b  [RESULT_LAT];
  logic [21:0]           pipe_ap [RESULT_LAT];
`ifdef BMU_TXN_CSR_EN
  logic [31:0]           pipe_csr [RESULT_LAT];
  logic                  unused_csr_ren;
`else
  logic                  unused_csr_data;
`endif

  txn_t         mem [DEPTH];
  txn_t         push_data;
  txn_t         head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic          write_en;
  logic          drop;

  // Without the CSR feature, CSR reads never enter the pipeline at all, so
  // they can neither be pushed nor be counted as drops.
`ifdef BMU_TXN_CSR_EN
  assign cap            = valid_in & ~scan_mode;
  assign unused_csr_ren = csr_ren_in;
`else
  assign cap             = valid_in & ~scan_mode & ~csr_ren_in;
  assign unused_csr_data = ^csr_rddata_in;
`endif

  // Alignment shift pipeline; reset clears only the valid bits, which is
  // enough to discard in-flight operations.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= cap;
      pipe_a[0]   <= a_in;
      pipe_b[0]   <= b_in;
      pipe_ap[0]  <= ap_in;
`ifdef BMU_TXN_CSR_EN
      pipe_csr[0] <= csr_rddata_in;
`endif
      for (int i = 1; i < RESULT_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_a[i]   <= pipe_a[i-1];
        pipe_b[i]   <= pipe_b[i-1];
        pipe_ap[i]  <= pipe_ap[i-1];
`ifdef BMU_TXN_CSR_EN
        pipe_csr[i] <= pipe_csr[i-1];
`endif
      end
    end
  end

  // Combine the oldest pipeline stage with the result arriving this cycle.
  always_comb begin
    push_data        = '0;
    push_data.a      = pipe_a[RESULT_LAT-1];
    push_data.b      = pipe_b[RESULT_LAT-1];
    push_data.ap     = pipe_ap[RESULT_LAT-1];
    push_data.result = result_ff;
    push_data.err    = error;
`ifdef BMU_TXN_CSR_EN
    push_data.csr    = pipe_csr[RESULT_LAT-1];
`endif
  end

  assign push  = pipe_vld[RESULT_LAT-1];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = txn_valid & txn_ready;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can still be accepted.
  assign write_en = push & (~full | pop);
  assign drop     = push & full & ~pop;

  // FIFO storage; contents need no reset because the pointers gate validity.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Read/write pointers with an extra wrap bit.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (write_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != {CNT_W{1'b1}}) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  assign txn_valid  = ~empty;
  assign fifo_level = wr_ptr - rd_ptr;
  assign head       = mem[rd_ptr[AW-1:0]];

  // Data outputs are forced to zero while the FIFO is empty so that stale
  // storage never leaks out after reset.
  assign txn_a      = txn_valid ? head.a      : '0;
  assign txn_b      = txn_valid ? head.b      : '0;
  assign txn_ap     = txn_valid ? head.ap     : '0;
  assign txn_result = txn_valid ? head.result : '0;
  assign txn_error  = txn_valid ? head.err    : 1'b0;
`ifdef BMU_TXN_CSR_EN
  assign txn_csr_data = txn_valid ? head.csr : '0;
`endif

endmodule

// File: tb/tb_bmu_txn_capture.sv
// tb_bmu_txn_capture: directed checks of bmu_txn_capture with a
// RESULT_LAT=1 instance and a RESULT_LAT=3 instance sharing stimulus.
module tb_bmu_txn_capture;

  localparam logic [21:0] AP_OP = 22'h000400;

  logic        clk;
  logic        rst_l;
  logic        valid_in;
  logic        scan_mode;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [21:0] ap_in;
  logic        csr_ren_in;
  logic [31:0] csr_rddata_in;
  logic [31:0] result_ff;
  logic        error;
  logic        txn_ready;

  logic        txn_valid,   txn_valid_3;
  logic [31:0] txn_a,       txn_a_3;
  logic [31:0] txn_b,       txn_b_3;
  logic [21:0] txn_ap,      txn_ap_3;
  logic [31:0] txn_result,  txn_result_3;
  logic        txn_error,   txn_error_3;
  logic        overflow,    overflow_3;
  logic [15:0] drop_cnt,    drop_cnt_3;
  logic [3:0]  fifo_level,  fifo_level_3;
`ifdef BMU_TXN_CSR_EN
  logic [31:0] txn_csr_data, txn_csr_data_3;
`endif

  int tests;
  int fails;

  bmu_txn_capture #(.RESULT_LAT(1), .DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_l(rst_l), .valid_in(valid_in), .scan_mode(scan_mode),
    .a_in(a_in), .b_in(b_in), .ap_in(ap_in), .csr_ren_in(csr_ren_in),
    .csr_rddata_in(csr_rddata_in), .result_ff(result_ff), .error(error),
    .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_a(txn_a), .txn_b(txn_b),
    .txn_ap(txn_ap), .txn_result(txn_result), .txn_error(txn_error),
`ifdef BMU_TXN_CSR_EN
    .txn_csr_data(txn_csr_data),
`endif
    .overflow(overflow), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
  );

  bmu_txn_capture #(.RESULT_LAT(3), .DEPTH(8), .CNT_W(16)) dut3 (
    .clk(clk), .rst_l(rst_l), .valid_in(valid_in), .scan_mode(scan_mode),
    .a_in(a_in), .b_in(b_in), .ap_in(ap_in), .csr_ren_in(csr_ren_in),
    .csr_rddata_in(csr_rddata_in), .result_ff(result_ff), .error(error),
    .txn_valid(txn_valid_3), .txn_ready(txn_ready), .txn_a(txn_a_3), .txn_b(txn_b_3),
    .txn_ap(txn_ap_3), .txn_result(txn_result_3), .txn_error(txn_error_3),
`ifdef BMU_TXN_CSR_EN
    .txn_csr_data(txn_csr_data_3),
`endif
    .overflow(overflow_3), .drop_cnt(drop_cnt_3), .fifo_level(fifo_level_3)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of issue-side inputs plus the result seen at the next edge.
  task automatic applyStimulus(input logic v, input logic scan, input logic ren,
                               input logic [31:0] a, input logic [31:0] res);
    valid_in   = v;
    scan_mode  = scan;
    csr_ren_in = ren;
    a_in       = a;
    b_in       = a ^ 32'hFF;
    ap_in      = AP_OP;
    result_ff  = res;
    error      = res[0];
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst_l         = 1'b1;
    valid_in      = 1'b0;
    scan_mode     = 1'b0;
    a_in          = '0;
    b_in          = '0;
    ap_in         = '0;
    csr_ren_in    = 1'b0;
    csr_rddata_in = '0;
    result_ff     = '0;
    error         = 1'b0;
    txn_ready     = 1'b0;

    tick();
    tick();
    rst_l = 1'b0;
    checkOutput("reset_valid",    64'(txn_valid),   64'd0);
    checkOutput("reset_level",    64'(fifo_level),  64'd0);
    checkOutput("reset_drop",     64'(drop_cnt),    64'd0);
    checkOutput("reset_overflow", 64'(overflow),    64'd0);
    checkOutput("reset_a",        64'(txn_a),       64'd0);
    checkOutput("reset_result",   64'(txn_result),  64'd0);
    checkOutput("reset_valid3",   64'(txn_valid_3), 64'd0);

    // Single operation, visible exactly one cycle after its result edge.
    txn_ready = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_00F0, 32'h0);
    checkOutput("single_early_valid", 64'(txn_valid), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("single_valid",  64'(txn_valid),  64'd1);
    checkOutput("single_a",      64'(txn_a),      64'h0F0);
    checkOutput("single_b",      64'(txn_b),      64'h00F);
    checkOutput("single_ap",     64'(txn_ap),     64'(AP_OP));
    checkOutput("single_result", 64'(txn_result), 64'd0);
    checkOutput("single_error",  64'(txn_error),  64'd0);
    checkOutput("single_level",  64'(fifo_level), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("single_pulse_end", 64'(txn_valid), 64'd0);

    // Back-pressure: 10 ops into an 8-deep FIFO, results 1..10.
    txn_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'(i), 32'(i - 1));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'd10);
    checkOutput("bp_level",    64'(fifo_level), 64'd8);
    checkOutput("bp_drop",     64'(drop_cnt),   64'd2);
    checkOutput("bp_overflow", 64'(overflow),   64'd1);
    tick();
    checkOutput("bp_stable_result", 64'(txn_result), 64'd1);
    checkOutput("bp_stable_a",      64'(txn_a),      64'd1);
    txn_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checkOutput("bp_drain_result", 64'(txn_result), 64'(i));
      checkOutput("bp_drain_error",  64'(txn_error),  64'(i % 2));
      tick();
    end
    checkOutput("bp_drained_valid", 64'(txn_valid),  64'd0);
    checkOutput("bp_drained_level", 64'(fifo_level), 64'd0);

    // Push into a full FIFO in the same cycle as a pop.
    txn_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h10 + 32'(i), 32'h20 + 32'(i - 1));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h19, 32'h28);
    checkOutput("full_level", 64'(fifo_level), 64'd8);
    checkOutput("full_drop",  64'(drop_cnt),   64'd2);
    txn_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h29);
    checkOutput("pushpop_level", 64'(fifo_level), 64'd8);
    checkOutput("pushpop_drop",  64'(drop_cnt),   64'd2);
    for (int i = 2; i <= 9; i++) begin
      checkOutput("pushpop_a",      64'(txn_a),      64'h10 + 64'(i));
      checkOutput("pushpop_result", 64'(txn_result), 64'h20 + 64'(i));
      tick();
    end
    checkOutput("pushpop_empty", 64'(txn_valid), 64'd0);

    // scan_mode blocks new captures but lets an in-flight op complete.
    txn_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hA1, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hA2, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'hA3, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h55, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h66);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("scan_level",  64'(fifo_level), 64'd1);
    checkOutput("scan_a",      64'(txn_a),      64'h55);
    checkOutput("scan_result", 64'(txn_result), 64'h66);
    txn_ready = 1'b1;
    tick();
    checkOutput("scan_drained", 64'(txn_valid), 64'd0);

    // CSR-read operation after a clean reset.
    rst_l = 1'b1;
    tick();
    rst_l         = 1'b0;
    txn_ready     = 1'b0;
    csr_rddata_in = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hC0, 32'h77);
    csr_rddata_in = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
`ifdef BMU_TXN_CSR_EN
    checkOutput("csr_level", 64'(fifo_level),   64'd1);
    checkOutput("csr_a",     64'(txn_a),        64'hC0);
    checkOutput("csr_data",  64'(txn_csr_data), 64'hDEAD_BEEF);
`else
    checkOutput("csr_level", 64'(fifo_level), 64'd0);
    checkOutput("csr_valid", 64'(txn_valid),  64'd0);
`endif
    checkOutput("csr_drop",     64'(drop_cnt), 64'd0);
    checkOutput("csr_overflow", 64'(overflow), 64'd0);

    // Reset with two ops in flight and three entries queued (RESULT_LAT=3).
    rst_l = 1'b1;
    tick();
    rst_l     = 1'b0;
    txn_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h30 + 32'(i), 32'h40 + 32'(i));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("lat3_level",  64'(fifo_level_3),  64'd3);
    checkOutput("lat3_a",      64'(txn_a_3),       64'h31);
    checkOutput("lat3_result", 64'(txn_result_3),  64'h44);
    txn_ready = 1'b1;
    rst_l     = 1'b1;
    tick();
    rst_l = 1'b0;
    checkOutput("midrst_level3", 64'(fifo_level_3), 64'd0);
    checkOutput("midrst_valid3", 64'(txn_valid_3),  64'd0);
    checkOutput("midrst_a3",     64'(txn_a_3),      64'd0);
    checkOutput("midrst_level1", 64'(fifo_level),   64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
    end
    checkOutput("late_level3", 64'(fifo_level_3), 64'd0);
    checkOutput("late_valid3", 64'(txn_valid_3),  64'd0);
    checkOutput("late_drop3",  64'(drop_cnt_3),   64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bmu_txn_capture.md
# bmu_txn_capture

Synthesizable transaction collector at the result side of the BMU. It samples each issued BMU operation (operands, op flags, CSR read data) and re-aligns it with the registered `result_ff`/`error` that appears `RESULT_LAT` cycles later. The completed transaction is pushed into an internal FIFO and presented on a ready/valid stream. An on-chip checker, trace buffer, or bench scoreboard drains that stream without having to track BMU latency itself.

## Interface
Parameters:
- `RESULT_LAT`, 1: cycles from a sampled `valid_in` to the matching `result_ff`/`error` (1..4).
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CNT_W`, 16: width of the drop counter.

Ports:
- `clk` input 1: the only clock; all logic updates on its rising edge.
- `rst_l` input 1: reset, synchronous and active-high.
- `valid_in` input 1: BMU operation issued this cycle.
- `scan_mode` input 1: while high, no new operation is captured.
- `a_in` input 32: operand 1 (signed).
- `b_in` input 32: operand 2 (signed).
- `ap_in` input 22: packed BMU op flags, `csr_write` in bit 21 down to `gorc` in bit 0.
- `csr_ren_in` input 1: the operation is a CSR read.
- `csr_rddata_in` input 32: CSR read data.
- `result_ff` input 32: BMU registered result.
- `error` input 1: BMU error flag.
- `txn_valid` output 1: FIFO head is valid.
- `txn_ready` input 1: consumer accepts the head.
- `txn_a`, `txn_b` output 32 each: captured operands.
- `txn_ap` output 22: captured op flags.
- `txn_result` output 32: captured result.
- `txn_error` output 1: captured error flag.
- `txn_csr_data` output 32: captured CSR read data (only present with `BMU_TXN_CSR_EN`).
- `overflow` output 1: sticky flag, set when any completed transaction is dropped.
- `drop_cnt` output `CNT_W`: count of dropped transactions; saturates at its maximum value.
- `fifo_level` output `$clog2(DEPTH)+1`: current FIFO occupancy.

## Operation
- **Capture qualifier.** `cap = valid_in & ~scan_mode`. Without `BMU_TXN_CSR_EN`, the term `& ~csr_ren_in` is added.
- **Alignment pipeline.** A shift pipeline `RESULT_LAT` stages deep carries {`cap`, `a_in`, `b_in`, `ap_in`, `csr_rddata_in`}. Back-to-back operations every cycle are supported, with no bubbles.
- **Pairing.** When the last pipeline stage is valid, it is combined with the current `result_ff` and `error` to form one transaction, and a push is requested.
- **FIFO.** Circular buffer with read/write pointers of `$clog2(DEPTH)+1` bits; the extra MSB distinguishes wrap.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
- **Pop.** `txn_valid & txn_ready`. The `txn_*` outputs show the head entry and stay stable while `txn_valid=1` and `txn_ready=0`.
- **Push while full without pop.** The transaction is dropped, `drop_cnt` increments (saturating), and `overflow` sets. FIFO contents are unchanged.
- **Push while full with pop in the same cycle.** The push is accepted and nothing is dropped; the level stays at `DEPTH`.
- **Push and pop in the same cycle when not full or empty.** The level is unchanged.
- **No bypass.** A transaction pushed into an empty FIFO appears on the next cycle.
- **Reset.** Flushes the pipeline and FIFO. In-flight operations are discarded and are not counted as drops.

## Timing
- **Reset values.** `txn_valid=0`, `overflow=0`, `drop_cnt=0`, `fifo_level=0`, all `txn_*` data outputs 0.
- **Capture.** An operation is sampled at rising edge T, and its result is sampled at edge T+`RESULT_LAT`.
- **Write and visibility.** The FIFO write happens at edge T+`RESULT_LAT`. `txn_valid` rises after that edge, so it is observable in cycle T+`RESULT_LAT`+1 relative to issue.
- **Counter and flag updates.** `fifo_level`, `drop_cnt` and `overflow` update at the same edge as the push or pop that changes them.
- **`scan_mode` scope.** It gates only new captures; operations already in the pipeline still complete.
- **Reset mid-transfer.** If `rst_l` is high at edge E, every output holds its reset value after E, regardless of `txn_ready`.

## Configuration
- **Macro `BMU_TXN_CSR_EN`, defined.**
  - CSR-read operations are captured.
  - `csr_rddata_in` is carried through the pipeline and FIFO.
  - The `txn_csr_data` port exists.
- **Macro `BMU_TXN_CSR_EN`, undefined.**
  - Operations with `csr_ren_in=1` are ignored: never pushed and not counted as drops.
  - No CSR data storage is built.
  - The `txn_csr_data` port is absent.

## Test plan
- **Single operation.** `RESULT_LAT=1`, `txn_ready=1`. Drive `valid_in` with `a_in=0x0000_00F0`, `b_in=0x0000_000F`, `ap_in` with the `land` bit set; `result_ff=0` on the next edge. Expect exactly one `txn_valid` pulse, 2 cycles after issue, with `txn_a=0xF0`, `txn_b=0x0F`, `txn_result=0`, `txn_error=0`.
- **Back-pressure and overflow.** `DEPTH=8`, `txn_ready=0`, 10 back-to-back operations with `result_ff` = 1..10. Expect `fifo_level=8`, `drop_cnt=2`, `overflow=1`. Then raise `txn_ready`: results 1..8 drain in order, and `txn_valid` drops after the eighth.
- **Simultaneous push and pop when full.** FIFO full, `txn_ready=1`, new operation completing in the same cycle. Expect `drop_cnt` unchanged and `fifo_level` to stay at 8.
- **`scan_mode` gating.** Hold `scan_mode=1` for 3 issued operations, then 1 operation with `scan_mode=0`. Expect exactly one transaction.
- **CSR capture.** Operation with `csr_ren_in=1` and `csr_rddata_in=0xDEAD_BEEF`. With `BMU_TXN_CSR_EN`, expect `txn_csr_data=0xDEAD_BEEF`. Without it, expect no transaction and `drop_cnt=0`.
- **Reset mid-flight.** `RESULT_LAT=3`, 2 operations in flight and 3 FIFO entries, then assert `rst_l` for one edge. Expect `fifo_level=0` and `txn_valid=0` after the edge, and no late push from the flushed operations.
